// File: rtl/cpu_serial_frontend_pkg.sv
// -----------------------------------------------------------------------------
// cpu_serial_frontend_pkg
// Shared definitions for the serial command front end. The state encodings are
// localparams so any debug mux that selects on state_o decodes the same values
// the FSM produces.
// -----------------------------------------------------------------------------
package cpu_serial_frontend_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] S_LOAD_A    = 3'd1;
  localparam logic [STATE_W-1:0] S_LOAD_B    = 3'd2;
  localparam logic [STATE_W-1:0] S_LOAD_OP   = 3'd3;
  localparam logic [STATE_W-1:0] S_ISSUE     = 3'd4;
  localparam logic [STATE_W-1:0] S_WAIT_RES  = 3'd5;
  localparam logic [STATE_W-1:0] S_SHIFT_OUT = 3'd6;
  localparam logic [STATE_W-1:0] S_DONE      = 3'd7;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = S_IDLE,
    LOAD_A    = S_LOAD_A,
    LOAD_B    = S_LOAD_B,
    LOAD_OP   = S_LOAD_OP,
    ISSUE     = S_ISSUE,
    WAIT_RES  = S_WAIT_RES,
    SHIFT_OUT = S_SHIFT_OUT,
    DONE      = S_DONE
  } state_e;

endpackage

// File: rtl/cpu_serial_frontend_if.sv
// -----------------------------------------------------------------------------
// cpu_serial_frontend_if
// Issue/result bus between the serial front end and the ALU/regfile datapath.
//   a_o, b_o, op_o   operands and opcode toward the datapath
//   issue_valid_o    operands/opcode valid
//   issue_ready_i    datapath accepts the issue
//   res_valid_i      datapath result valid
//   res_i, flags_i   datapath result and flags
// master: the front end.  slave: the datapath.
// -----------------------------------------------------------------------------
interface cpu_serial_frontend_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4,
  parameter int FLAG_W = 4
);
  logic [DATA_W-1:0] a_o;
  logic [DATA_W-1:0] b_o;
  logic [OP_W-1:0]   op_o;
  logic              issue_valid_o;
  logic              issue_ready_i;
  logic              res_valid_i;
  logic [DATA_W-1:0] res_i;
  logic [FLAG_W-1:0] flags_i;

  modport master (
    output a_o, b_o, op_o, issue_valid_o,
    input  issue_ready_i, res_valid_i, res_i, flags_i
  );

  modport slave (
    input  a_o, b_o, op_o, issue_valid_o,
    output issue_ready_i, res_valid_i, res_i, flags_i
  );
endinterface

// File: rtl/cpu_serial_frontend_shift_reg.sv
// -----------------------------------------------------------------------------
// cpu_shift_reg
// Parametrised shift register, shifting toward the MSB.
//   clk, rst   clock, asynchronous active-high reset (clears to zero)
//   load       parallel load of load_val (wins over shift_en)
//   shift_en   shift left by one, ser_in entering at the LSB
//   q          register contents
//   ser_out    current MSB (serial output, MSB first)
// -----------------------------------------------------------------------------
module cpu_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out
);

  logic [WIDTH-1:0] shifted;

  generate
    if (WIDTH == 1) begin : g_single
      assign shifted = ser_in;
    end else begin : g_multi
      assign shifted = {q[WIDTH-2:0], ser_in};
    end
  endgenerate

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           q <= '0;
    else if (load)     q <= load_val;
    else if (shift_en) q <= shifted;
  end

  assign ser_out = q[WIDTH-1];

endmodule

// File: rtl/cpu_serial_frontend.sv
// -----------------------------------------------------------------------------
// cpu_serial_frontend
// Deserialises a frame (A, B, opcode; MSB first) from ser_i, issues it to the
// datapath over a valid/ready handshake, captures the result and flags,
// optionally shifts the result out on ser_o, then pulses done_o.
//   clk, rst        clock, asynchronous active-high reset
//   start_i         begins a frame when sampled high in IDLE
//   abort_i         returns to IDLE from any state, no done_o
//   ser_i           serial frame input
//   bus (master)    issue/result handshake toward the datapath
//   result_o/flags_o last captured result and flags
//   ser_o/ser_valid_o serial result (MSB first) and qualifier
//   busy_o          high outside IDLE
//   done_o          one-cycle completion pulse
//   state_o         current state encoding (debug)
// OP_W must not exceed DATA_W: one bit counter serves all phases.
// -----------------------------------------------------------------------------
import cpu_serial_frontend_pkg::*;

module cpu_serial_frontend #(
  parameter int DATA_W     = 8,
  parameter int OP_W       = 4,
  parameter int FLAG_W     = 4,
  parameter int OUT_SERIAL = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 ser_i,
  cpu_serial_frontend_if.master bus,
  output logic [DATA_W-1:0]    result_o,
  output logic [FLAG_W-1:0]    flags_o,
  output logic                 ser_o,
  output logic                 ser_valid_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [STATE_W-1:0]   state_o
);

  localparam int     CNT_W     = $clog2(DATA_W);
  localparam state_e AFTER_CAP = (OUT_SERIAL != 0) ? SHIFT_OUT : DONE;

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             issue_valid;
  logic             last_data, last_op, counting, capture;
  logic             a_ser_unused, b_ser_unused, op_ser_unused;
  logic [DATA_W-1:0] out_q_unused;

  assign last_data = (cnt == CNT_W'(DATA_W - 1));
  assign last_op   = (cnt == CNT_W'(OP_W - 1));
  assign counting  = state inside {LOAD_A, LOAD_B, LOAD_OP, SHIFT_OUT};

  // issue_valid_o is high exactly while in ISSUE, so the handshake is the
  // state qualified by ready. A same-edge res_valid_i captures immediately.
  assign capture = !abort_i && bus.res_valid_i &&
                   ((state == ISSUE && bus.issue_ready_i) || state == WAIT_RES);

  // NOTE: state_n gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    if (abort_i) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:      if (start_i)           state_n = LOAD_A;
        LOAD_A:    if (last_data)         state_n = LOAD_B;
        LOAD_B:    if (last_data)         state_n = LOAD_OP;
        LOAD_OP:   if (last_op)           state_n = ISSUE;
        ISSUE:     if (bus.issue_ready_i) state_n = bus.res_valid_i ? AFTER_CAP : WAIT_RES;
        WAIT_RES:  if (bus.res_valid_i)   state_n = AFTER_CAP;
        SHIFT_OUT: if (last_data)         state_n = DONE;
        DONE:                             state_n = IDLE;
        default:                          state_n = IDLE;
      endcase
    end
  end

  // Outputs are registered copies of the next state, so they line up with
  // state_o and never depend combinationally on an input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      result_o    <= '0;
      flags_o     <= '0;
      issue_valid <= 1'b0;
      ser_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n != state) cnt <= '0;
      else if (counting)    cnt <= cnt + CNT_W'(1);
      if (capture) begin
        result_o <= bus.res_i;
        flags_o  <= bus.flags_i;
      end
      issue_valid <= (state_n == ISSUE);
      ser_valid_o <= (state_n == SHIFT_OUT);
      busy_o      <= (state_n != IDLE);
      done_o      <= (state_n == DONE);
    end
  end

  assign bus.issue_valid_o = issue_valid;
  assign state_o           = state;

  // Operand registers hold their partial contents on abort: no shift that edge.
  cpu_shift_reg #(.WIDTH(DATA_W)) u_a (
    .clk(clk), .rst(rst), .load(1'b0), .load_val('0),
    .shift_en(state == LOAD_A && !abort_i), .ser_in(ser_i),
    .q(bus.a_o), .ser_out(a_ser_unused)
  );

  cpu_shift_reg #(.WIDTH(DATA_W)) u_b (
    .clk(clk), .rst(rst), .load(1'b0), .load_val('0),
    .shift_en(state == LOAD_B && !abort_i), .ser_in(ser_i),
    .q(bus.b_o), .ser_out(b_ser_unused)
  );

  cpu_shift_reg #(.WIDTH(OP_W)) u_op (
    .clk(clk), .rst(rst), .load(1'b0), .load_val('0),
    .shift_en(state == LOAD_OP && !abort_i), .ser_in(ser_i),
    .q(bus.op_o), .ser_out(op_ser_unused)
  );

  // Loaded on the capture edge so the MSB is on ser_o the very next cycle.
  cpu_shift_reg #(.WIDTH(DATA_W)) u_out (
    .clk(clk), .rst(rst), .load(capture && (OUT_SERIAL != 0)), .load_val(bus.res_i),
    .shift_en(state == SHIFT_OUT && !abort_i), .ser_in(1'b0),
    .q(out_q_unused), .ser_out(ser_o)
  );

endmodule

// File: tb/tb_cpu_serial_frontend.sv
// -----------------------------------------------------------------------------
// tb_cpu_serial_frontend
// Two instances: dut0 (DATA_W=8, OP_W=4, OUT_SERIAL=1) and dut1 (DATA_W=16,
// OP_W=5, OUT_SERIAL=0). The bench plays the datapath; expected results come
// from a plain arithmetic ALU model applied to the frame the bench sent.
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_cpu_serial_frontend;
  import cpu_serial_frontend_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       start, abort_s, ser, ready, resv;
  logic [1:0][15:0] res;
  logic [1:0][3:0]  flg;
  logic [1:0]       iv, sero, serv, busy, done;
  logic [1:0][2:0]  st;
  logic [1:0][3:0]  flags_m;
  logic [1:0][15:0] a_m, b_m, result_m;
  logic [1:0][4:0]  op_m;
  logic [1:0][15:0] last_res;
  logic [1:0][3:0]  last_flg;
  logic [7:0]       res0_q;

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt[2]  = '{0, 0};
  int issue_cnt[2] = '{0, 0};
  int serv_cnt[2]  = '{0, 0};

  cpu_serial_frontend_if #(.DATA_W(8),  .OP_W(4), .FLAG_W(4)) bus0 ();
  cpu_serial_frontend_if #(.DATA_W(16), .OP_W(5), .FLAG_W(4)) bus1 ();

  assign bus0.issue_ready_i = ready[0];
  assign bus0.res_valid_i   = resv[0];
  assign bus0.res_i         = res[0][7:0];
  assign bus0.flags_i       = flg[0];
  assign bus1.issue_ready_i = ready[1];
  assign bus1.res_valid_i   = resv[1];
  assign bus1.res_i         = res[1];
  assign bus1.flags_i       = flg[1];

  assign a_m[0]      = {8'h00, bus0.a_o};
  assign b_m[0]      = {8'h00, bus0.b_o};
  assign op_m[0]     = {1'b0, bus0.op_o};
  assign iv[0]       = bus0.issue_valid_o;
  assign result_m[0] = {8'h00, res0_q};
  assign a_m[1]      = bus1.a_o;
  assign b_m[1]      = bus1.b_o;
  assign op_m[1]     = bus1.op_o;
  assign iv[1]       = bus1.issue_valid_o;

  cpu_serial_frontend #(.DATA_W(8), .OP_W(4), .FLAG_W(4), .OUT_SERIAL(1)) dut0 (
    .clk(clk), .rst(rst), .start_i(start[0]), .abort_i(abort_s[0]), .ser_i(ser[0]),
    .bus(bus0), .result_o(res0_q), .flags_o(flags_m[0]), .ser_o(sero[0]),
    .ser_valid_o(serv[0]), .busy_o(busy[0]), .done_o(done[0]), .state_o(st[0])
  );

  cpu_serial_frontend #(.DATA_W(16), .OP_W(5), .FLAG_W(4), .OUT_SERIAL(0)) dut1 (
    .clk(clk), .rst(rst), .start_i(start[1]), .abort_i(abort_s[1]), .ser_i(ser[1]),
    .bus(bus1), .result_o(result_m[1]), .flags_o(flags_m[1]), .ser_o(sero[1]),
    .ser_valid_o(serv[1]), .busy_o(busy[1]), .done_o(done[1]), .state_o(st[1])
  );

  // Event counters sample pre-edge values, as the DUT itself does.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (done[k])           done_cnt[k]++;
      if (iv[k] && ready[k]) issue_cnt[k]++;
      if (serv[k])           serv_cnt[k]++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mask(int w);
    return 16'((32'd1 << w) - 1);
  endfunction

  // Reference ALU: op[1:0] selects add/sub/and/xor; returns {C,Z,V,N, result}.
  function automatic logic [19:0] alu(int dw, logic [4:0] op, logic [15:0] a, logic [15:0] b);
    logic [16:0] full;
    logic [15:0] r;
    logic        c, z, v, n, am, bm;
    case (op[1:0])
      2'd0:    full = {1'b0, a} + {1'b0, b};
      2'd1:    full = {1'b0, a} - {1'b0, b};
      2'd2:    full = {1'b0, a & b};
      default: full = {1'b0, a ^ b};
    endcase
    r  = full[15:0] & mask(dw);
    c  = (op[1:0] < 2'd2) ? full[dw] : 1'b0;
    z  = (r == 16'h0);
    n  = r[dw-1];
    am = a[dw-1];
    bm = b[dw-1];
    case (op[1:0])
      2'd0:    v = (am == bm) && (n != am);
      2'd1:    v = (am != bm) && (n != am);
      default: v = 1'b0;
    endcase
    return {c, z, v, n, r};
  endfunction

  task automatic check_reset(int k);
    check("rst_state", st[k], S_IDLE);
    check("rst_busy", busy[k], 0);
    check("rst_issue_valid", iv[k], 0);
    check("rst_done", done[k], 0);
    check("rst_ser_valid", serv[k], 0);
    check("rst_ser", sero[k], 0);
    check("rst_a", a_m[k], 0);
    check("rst_b", b_m[k], 0);
    check("rst_op", op_m[k], 0);
    check("rst_result", result_m[k], 0);
    check("rst_flags", flags_m[k], 0);
  endtask

  // Starts a frame and shifts it in; returns at the falling edge after the
  // last op bit edge, where issue_valid_o must just have risen.
  task automatic send_frame(int k, int dw, int ow, logic [15:0] a, logic [15:0] b, logic [4:0] op);
    int n;
    n = 2 * dw + ow;
    @(negedge clk);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    check("busy_after_start", busy[k], 1);
    for (int i = 0; i < n; i++) begin
      if (i < dw)          ser[k] = a[dw-1-i];
      else if (i < 2 * dw) ser[k] = b[2*dw-1-i];
      else                 ser[k] = op[n-1-i];
      // res_valid_i noise while loading must be ignored.
      resv[k] = 1'($urandom_range(0, 1));
      res[k]  = 16'($urandom);
      flg[k]  = 4'($urandom);
      if (i == n - 1) check("issue_not_early", iv[k], 0);
      @(negedge clk);
    end
    resv[k] = 1'b0;
    check("issue_latency", iv[k], 1);
    check("issue_a", a_m[k], a);
    check("issue_b", b_m[k], b);
    check("issue_op", op_m[k], op);
  endtask

  task automatic run_frame(int k, int dw, int ow, bit os, logic [15:0] a, logic [15:0] b,
                           logic [4:0] op, int stall, bit same_edge, int delay);
    logic [19:0] r;
    logic [15:0] shifted;
    int d0, i0;
    a  = a & mask(dw);
    b  = b & mask(dw);
    op = op & 5'(mask(ow));
    r  = alu(dw, op, a, b);
    d0 = done_cnt[k];
    i0 = issue_cnt[k];
    send_frame(k, dw, ow, a, b, op);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", iv[k], 1);
      check("stall_a", a_m[k], a);
      check("stall_b", b_m[k], b);
      check("stall_op", op_m[k], op);
    end
    ready[k] = 1'b1;
    resv[k]  = same_edge;
    res[k]   = same_edge ? r[15:0] : 16'($urandom);
    flg[k]   = same_edge ? r[19:16] : 4'($urandom);
    @(negedge clk);
    ready[k] = 1'b0;
    resv[k]  = 1'b0;
    check("single_issue", iv[k], 0);
    if (!same_edge) begin
      check("wait_res_state", st[k], S_WAIT_RES);
      for (int d = 0; d < delay; d++) @(negedge clk);
      resv[k] = 1'b1;
      res[k]  = r[15:0];
      flg[k]  = r[19:16];
      @(negedge clk);
      resv[k] = 1'b0;
    end
    res[k] = 16'($urandom);
    check("result", result_m[k], r[15:0]);
    check("flags", flags_m[k], r[19:16]);
    last_res[k] = r[15:0];
    last_flg[k] = r[19:16];
    if (os) begin
      check("shift_after_capture", st[k], S_SHIFT_OUT);
      shifted = '0;
      for (int j = 0; j < dw; j++) begin
        check("ser_valid", serv[k], 1);
        shifted = {shifted[14:0], sero[k]};
        resv[k] = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      resv[k] = 1'b0;
      check("ser_sequence", shifted, r[15:0]);
      check("ser_valid_drop", serv[k], 0);
    end else begin
      check("no_ser_valid", serv[k], 0);
    end
    check("done_pulse", done[k], 1);
    check("result_hold", result_m[k], r[15:0]);
    @(negedge clk);
    check("done_one_cycle", done[k], 0);
    check("idle_after_done", busy[k], 0);
    check("done_count", done_cnt[k] - d0, 1);
    check("issue_count", issue_cnt[k] - i0, 1);
  endtask

  // Loads all of A and two bits of B, aborts on the third B bit.
  task automatic abort_frame(int k, int dw, logic [15:0] a, logic [15:0] b);
    int d0;
    a  = a & mask(dw);
    d0 = done_cnt[k];
    @(negedge clk);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    for (int i = 0; i < dw + 2; i++) begin
      ser[k] = (i < dw) ? a[dw-1-i] : b[2*dw-1-i];
      @(negedge clk);
    end
    ser[k]     = b[dw-3];
    abort_s[k] = 1'b1;
    @(negedge clk);
    abort_s[k] = 1'b0;
    check("abort_state", st[k], S_IDLE);
    check("abort_busy", busy[k], 0);
    check("abort_a_kept", a_m[k], a);
    check("abort_result_kept", result_m[k], last_res[k]);
    check("abort_flags_kept", flags_m[k], last_flg[k]);
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt[k] - d0, 0);
    check("abort_stays_idle", st[k], S_IDLE);
  endtask

  initial begin
    logic [19:0] r;
    rst      = 1'b1;
    start    = 2'b11;  // start held during reset must not begin a frame
    abort_s  = '0;
    ser      = '0;
    ready    = '0;
    resv     = '0;
    res      = '0;
    flg      = '0;
    last_res = '0;
    last_flg = '0;
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    start = '0;
    rst   = 1'b0;
    @(negedge clk);
    check("idle_after_rst0", st[0], S_IDLE);
    check("idle_after_rst1", st[1], S_IDLE);

    // dut0: directed add frame, backpressure, same-edge result, abort
    run_frame(0, 8, 4, 1, 16'h0B, 16'h0F, 5'd0, 0, 0, 1);
    check("directed_result", result_m[0], 16'h1A);
    run_frame(0, 8, 4, 1, 16'($urandom), 16'($urandom), 5'($urandom), 5, 0, 2);
    run_frame(0, 8, 4, 1, 16'($urandom), 16'($urandom), 5'($urandom), 0, 1, 0);
    abort_frame(0, 8, 16'($urandom), 16'($urandom));
    run_frame(0, 8, 4, 1, 16'($urandom), 16'($urandom), 5'($urandom), 1, 0, 0);
    for (int t = 0; t < 6; t++)
      run_frame(0, 8, 4, 1, 16'($urandom), 16'($urandom), 5'($urandom),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3));

    // dut1: wide frame, no serial output
    run_frame(1, 16, 5, 0, 16'h1234, 16'h0001, 5'd0, 0, 0, 0);
    check("wide_directed_result", result_m[1], 16'h1235);
    run_frame(1, 16, 5, 0, 16'($urandom), 16'($urandom), 5'($urandom), 0, 1, 0);
    abort_frame(1, 16, 16'($urandom), 16'($urandom));
    for (int t = 0; t < 3; t++)
      run_frame(1, 16, 5, 0, 16'($urandom), 16'($urandom), 5'($urandom),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    check("out_serial0_never_valid", serv_cnt[1], 0);

    // Reset in the middle of SHIFT_OUT on dut0
    r = alu(8, 5'd0, 16'h5A, 16'h33);
    send_frame(0, 8, 4, 16'h5A, 16'h33, 5'd0);
    ready[0] = 1'b1;
    resv[0]  = 1'b1;
    res[0]   = r[15:0];
    flg[0]   = r[19:16];
    @(negedge clk);
    ready[0] = 1'b0;
    resv[0]  = 1'b0;
    @(negedge clk);
    check("pre_reset_shifting", st[0], S_SHIFT_OUT);
    #2;
    rst      = 1'b1;
    start[0] = 1'b1;
    #1;
    check_reset(0);
    repeat (3) @(negedge clk);
    check("start_during_reset", st[0], S_IDLE);
    check("busy_during_reset", busy[0], 0);
    start[0] = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    check("idle_after_mid_reset", st[0], S_IDLE);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_serial_frontend.md
# cpu_serial_frontend

Parametrised serial command front end for the CPU datapath, generalising the 8-bit serial loader. It deserialises a frame (operand A, operand B, opcode) from a single input pin and issues it to the ALU/regfile over a valid/ready handshake. It then captures result and flags, optionally shifts the result back out serially, and reports completion. Width, opcode size and output mode are parameters, and frames can be aborted.

## Interface
- `DATA_W`, 8: operand/result width in bits (≥2)
- `OP_W`, 4: opcode width in bits (≥1)
- `FLAG_W`, 4: flag vector width (C,Z,V,N at 4)
- `OUT_SERIAL`, 1: 1 = shift result out on `ser_o`; 0 = skip serial output phase
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start_i`  in  1  begins a frame when sampled high in IDLE
- `abort_i`  in  1  cancels current frame, any state
- `ser_i`  in  1  serial frame bit, MSB first
- `a_o`, `b_o`  out  DATA_W  deserialised operands
- `op_o`  out  OP_W  deserialised opcode
- `issue_valid_o`  out  1  operands/opcode valid toward datapath
- `issue_ready_i`  in  1  datapath accepts issue
- `res_valid_i`  in  1  datapath result valid
- `res_i`  in  DATA_W  datapath result
- `flags_i`  in  FLAG_W  datapath flags
- `result_o`  out  DATA_W  last captured result
- `flags_o`  out  FLAG_W  last captured flags
- `ser_o`, `ser_valid_o`  out  1  serial result bit (MSB first) and its qualifier
- `busy_o`  out  1  high in every state except IDLE
- `done_o`  out  1  one-cycle completion pulse
- `state_o`  out  3  current state encoding, for the debug output mux

## Operation
- States: IDLE, LOAD_A, LOAD_B, LOAD_OP, ISSUE, WAIT_RES, SHIFT_OUT, DONE.
- IDLE: `start_i`=1 → LOAD_A and clear the bit counter. `start_i` is ignored in all other states.
- LOAD_A/LOAD_B/LOAD_OP: shift `ser_i` into the LSB of the target register on every edge. After DATA_W, DATA_W, OP_W bits respectively, go to the next state.
- ISSUE: `issue_valid_o`=1. `a_o`/`b_o`/`op_o` stay stable until `issue_valid_o && issue_ready_i`.
  - On that handshake edge, go to WAIT_RES.
  - If `res_valid_i` is also high on the handshake edge, capture the result and skip WAIT_RES.
- WAIT_RES: on the `res_valid_i` edge, load `result_o`/`flags_o`. Next state is SHIFT_OUT when OUT_SERIAL=1, otherwise DONE. `res_valid_i` is ignored outside ISSUE/WAIT_RES.
- SHIFT_OUT: drive `result_o` MSB first for DATA_W cycles with `ser_valid_o`=1, then go to DONE.
- DONE: `done_o`=1 for one cycle, then IDLE.
- `abort_i` takes priority over every other transition: next state is IDLE, and no `done_o` pulse is produced.
  - `a_o`/`b_o`/`op_o` keep their partial contents.
  - `result_o`/`flags_o` are not updated.
- Bit counter width is $clog2(DATA_W); it wraps to 0 at each phase boundary.

## Timing
- Reset values: state IDLE; `a_o`, `b_o`, `op_o`, `result_o`, `flags_o` all zero; `issue_valid_o`, `ser_o`, `ser_valid_o`, `busy_o`, `done_o` all 0; `state_o`=0 (IDLE).
- `start_i` high at edge t0 → A bits sampled at edges t0+1 … t0+DATA_W. B and op follow back to back with no gap.
- `issue_valid_o` rises after edge t0+2·DATA_W+OP_W. Minimum start→issue latency is 2·DATA_W+OP_W+1 cycles.
- Result → first `ser_o` bit: 1 cycle. `done_o` asserts the cycle after the last serial bit, or the cycle after capture when OUT_SERIAL=0.
- All outputs are registered; there is no combinational path from any input to any output.
- Reset asserted mid-frame forces all reset values immediately (asynchronous reset).

## Structure
- State encodings go in the shared states header as localparams, so `state_o` decodes consistently with the mux-select debug path.
- Sub-module `cpu_shift_reg` (parametrised WIDTH, parallel load, serial in/out, shift enable). Instantiate it for A, B, op, and the output shifter.

## Test plan
- DATA_W=8, OUT_SERIAL=1: A=0x0B, B=0x0F, op=0, model ALU adds → `issue_valid_o` 21 cycles after start, `result_o`=0x1A, `ser_o` sequence 00011010, single `done_o`.
- Backpressure: hold `issue_ready_i` low 5 cycles → `a_o`/`b_o`/`op_o` stable and `issue_valid_o` high throughout; one issue only.
- Handshake and `res_valid_i` on the same edge → WAIT_RES skipped; SHIFT_OUT starts next cycle.
- `abort_i` at the 3rd bit of B → IDLE next cycle, `busy_o`=0, no `done_o`, `result_o` unchanged. A new start then completes a normal frame.
- DATA_W=16, OP_W=5, OUT_SERIAL=0: A=0x1234, B=0x0001, add → `result_o`=0x1235; `ser_valid_o` never asserts; `done_o` the cycle after capture.
- `rst` asserted mid SHIFT_OUT → all outputs return to reset values asynchronously; `start_i` held high during reset starts no frame.
